// File: rtl/bht_if.sv
// bht_if: groups the update, lookup and flush signals of the branch history table.
interface bht_if;
    logic        debug_mode_i;
    logic        flush_bht_i;
    logic        update_valid_i;
    logic [63:0] update_pc_i;
    logic        update_is_branch_i;
    logic        update_taken_i;
    logic [63:0] lookup_pc_i;
    logic        predict_valid_o;
    logic        predict_taken_o;
    logic        busy_o;
    modport slave (
        input  debug_mode_i, flush_bht_i, update_valid_i, update_pc_i,
               update_is_branch_i, update_taken_i, lookup_pc_i,
        output predict_valid_o, predict_taken_o, busy_o
    );
    modport master (
        output debug_mode_i, flush_bht_i, update_valid_i, update_pc_i,
               update_is_branch_i, update_taken_i, lookup_pc_i,
        input  predict_valid_o, predict_taken_o, busy_o
    );
endinterface

// File: rtl/bht_update_unit.sv
// bht_update_unit: untagged 2-bit-counter branch history table with a sequential flush engine.
module bht_update_unit #(
    parameter int NR_ENTRIES = 1024,
    parameter int INDEX_LSB  = 1
) (
    input logic   clk_i,
    input logic   rst_i,
    bht_if.slave  bus
);
    localparam int IW = $clog2(NR_ENTRIES);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [NR_ENTRIES-1:0] valid;
    logic [1:0]      cnt [NR_ENTRIES];
    logic [IW-1:0]   idx_u, idx_l;
    logic            do_upd;
    logic [1:0]      cnt_cur, cnt_n;
    assign idx_u   = bus.update_pc_i[INDEX_LSB +: IW];
    assign idx_l   = bus.lookup_pc_i[INDEX_LSB +: IW];
    assign cnt_cur = cnt[idx_u];
    // a flush pulse in IDLE takes priority over the update arriving with it
    assign do_upd  = bus.update_valid_i && bus.update_is_branch_i && !bus.debug_mode_i
                     && state == IDLE && !bus.flush_bht_i;
    assign cnt_n = !valid[idx_u] ? (bus.update_taken_i ? 2'b10 : 2'b01)
                 : bus.update_taken_i ? (cnt_cur == 2'b11 ? 2'b11 : cnt_cur + 2'b01)
                 : (cnt_cur == 2'b00 ? 2'b00 : cnt_cur - 2'b01);
    assign bus.busy_o          = state == CLEAR;
    assign bus.predict_valid_o = valid[idx_l] && state == IDLE;
    assign bus.predict_taken_o = bus.predict_valid_o && cnt[idx_l][1];
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        if (bus.flush_bht_i) begin
            state_n = CLEAR;
            ptr_n   = '0;
        end else if (state == CLEAR) begin
            ptr_n   = ptr + IW'(1);
            if (ptr == IW'(NR_ENTRIES - 1)) begin
                state_n = IDLE;
                ptr_n   = '0;
            end
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) cnt[i] <= 2'b00;
        end else if (state == CLEAR) begin
            valid[ptr] <= 1'b0;
            cnt[ptr]   <= 2'b00;
        end else if (do_upd) begin
            valid[idx_u] <= 1'b1;
            cnt[idx_u]   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_bht_update_unit.sv
// tb_bht_update_unit: directed scoreboard bench for the 16-entry branch history table.
module tb_bht_update_unit;
    logic clk = 0;
    logic rst = 0;
    int   errors = 0;
    int   checks = 0;
    typedef struct { string tag; logic [2:0] exp; } item_t;
    item_t sb[$];
    bht_if bus();
    bht_update_unit #(.NR_ENTRIES(16), .INDEX_LSB(1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // expected {valid,taken,busy} is queued at drive time, compared once outputs settle
    task automatic look(input string tag, input logic [63:0] pc, input logic v, input logic t, input logic b);
        item_t it;
        logic [2:0] obs;
        bus.lookup_pc_i = pc;
        sb.push_back('{tag, {v, t, b}});
        #1;
        it  = sb.pop_front();
        obs = {bus.predict_valid_o, bus.predict_taken_o, bus.busy_o};
        checks++;
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
        end
    endtask
    task automatic upd(input logic [63:0] pc, input logic t);
        bus.update_valid_i = 1; bus.update_is_branch_i = 1;
        bus.update_pc_i = pc; bus.update_taken_i = t;
        tick();
        bus.update_valid_i = 0;
    endtask
    initial begin
        logic exp_t [6] = '{1, 1, 1, 1, 1, 0};
        int n;
        bus.debug_mode_i = 0; bus.flush_bht_i = 0; bus.update_valid_i = 0;
        bus.update_pc_i = 0; bus.update_is_branch_i = 0; bus.update_taken_i = 0;
        bus.lookup_pc_i = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
        look("reset", 64'h8000_0000, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            upd(64'h1002, i < 4);
            look($sformatf("sat_step%0d", i), 64'h1002, 1, exp_t[i], 0);
        end
        bus.update_valid_i = 1; bus.update_is_branch_i = 1;
        bus.update_pc_i = 64'h2004; bus.update_taken_i = 1;
        look("same_cycle_no_bypass", 64'h2004, 0, 0, 0);
        tick();
        bus.update_valid_i = 0;
        look("next_cycle_visible", 64'h2004, 1, 1, 0);
        bus.update_valid_i = 1; bus.update_is_branch_i = 0; bus.update_pc_i = 64'h8;
        tick();
        look("not_branch_ignored", 64'h8, 0, 0, 0);
        bus.update_is_branch_i = 1; bus.debug_mode_i = 1;
        tick();
        bus.update_valid_i = 0; bus.debug_mode_i = 0;
        look("debug_ignored", 64'h8, 0, 0, 0);
        for (int i = 0; i < 16; i++) upd(64'(i * 2), 1);
        look("populated", 64'hA, 1, 1, 0);
        bus.update_valid_i = 1; bus.update_pc_i = 64'h1E; bus.update_taken_i = 0;
        bus.flush_bht_i = 1;
        tick();
        bus.flush_bht_i = 0;
        n = 0;
        while (bus.busy_o && n < 100) begin
            n++;
            if (n == 3) look("clear_pred_invalid", 64'h1C, 0, 0, 1);
            tick();
        end
        bus.update_valid_i = 0;
        chk("flush_len", n, 16);
        for (int i = 0; i < 16; i++)
            look($sformatf("cleared_e%0d", i), 64'(i * 2), 0, 0, 0);
        upd(64'h4, 1);
        bus.flush_bht_i = 1;
        tick();
        bus.flush_bht_i = 0;
        n = 0;
        while (bus.busy_o && n < 100) begin
            n++;
            if (n == 7) bus.flush_bht_i = 1;
            tick();
            bus.flush_bht_i = 0;
        end
        chk("restart_len", n, 23);
        look("restart_cleared", 64'h4, 0, 0, 0);
        upd(64'hA, 1);
        bus.flush_bht_i = 1;
        tick();
        bus.flush_bht_i = 0;
        tick(); tick(); tick(); tick();
        #2 rst = 1;
        look("rst_mid_clear", 64'hA, 0, 0, 0);
        #3 rst = 0;
        tick();
        look("rst_entry_invalid", 64'h6, 0, 0, 0);
        upd(64'h6, 1);
        look("post_rst_update", 64'h6, 1, 1, 0);
        upd(64'h6, 0);
        upd(64'h6, 0);
        look("post_rst_floor", 64'h6, 1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bht_update_unit.md
Name: bht_update_unit

Overview:
Branch history table living in the frontend. It consumes resolved-branch reports from the execute stage: one report per cycle, carrying PC, taken/not-taken, valid and a conditional-branch flag. It keeps per-entry 2-bit saturating counters and answers single-cycle taken/not-taken prediction lookups for the fetch PC. A sequential flush engine invalidates the table one entry per cycle.

Parameters:
NR_ENTRIES, 1024, number of table entries; power of two, ≥ 4.
INDEX_LSB, 1, lowest PC bit used for indexing (1 = compressed-instruction granularity).

Ports:
clk_i  input  1  clock.
rst_i  input  1  asynchronous active-high reset.
debug_mode_i  input  1  when high, updates are ignored; lookups continue.
flush_bht_i  input  1  single-cycle pulse; starts a full-table clear.
update_valid_i  input  1  resolved-branch report valid.
update_pc_i  input  64  PC of the resolved instruction.
update_is_branch_i  input  1  report is a conditional branch; other control flow never updates.
update_taken_i  input  1  resolved outcome.
lookup_pc_i  input  64  fetch PC to predict.
predict_valid_o  output  1  indexed entry valid and table not clearing.
predict_taken_o  output  1  MSB of indexed counter, gated by predict_valid_o.
busy_o  output  1  flush engine active.

Behaviour:
- Index: IDX = pc[INDEX_LSB+log2(NR_ENTRIES)-1 : INDEX_LSB]. No tag; aliasing is accepted.
- Each entry holds a valid bit and a 2-bit counter. Reset value of every entry is {valid=0, cnt=00}.
- Output reset values: predict_valid_o=0, predict_taken_o=0, busy_o=0. Flush state is IDLE and the clear pointer is 0.
- Lookup is combinational from lookup_pc_i and the current table state, with no bypass.
  - An update to the same index in the same cycle is not visible until the next cycle.
- Update condition: update_valid_i && update_is_branch_i && !debug_mode_i && state==IDLE. When the condition holds, the write is registered at the clock edge.
  - Entry invalid: set valid=1, cnt = taken ? 10 : 01.
  - Entry valid, taken: cnt = min(cnt+1, 11).
  - Entry valid, not taken: cnt = max(cnt-1, 00).
  - Saturation is strict; the counter never wraps.
- Flush FSM, IDLE:
  - flush_bht_i → CLEAR, pointer := 0.
  - An update presented in the same cycle as flush_bht_i is dropped.
- Flush FSM, CLEAR:
  - Each cycle, entry[pointer] := {0, 00} and the pointer increments.
  - When pointer == NR_ENTRIES-1 the entry is cleared and the FSM returns to IDLE.
  - A CLEAR therefore lasts exactly NR_ENTRIES cycles.
  - busy_o=1 for all CLEAR cycles.
  - predict_valid_o=0 and all updates are dropped while in CLEAR.
- flush_bht_i asserted during CLEAR restarts the clear: pointer := 0, stay in CLEAR.
- rst_i asserted at any time, including mid-CLEAR: all entries cleared immediately, FSM to IDLE, outputs to reset values.
- Pointer width is log2(NR_ENTRIES). Its terminal value is detected explicitly, never by overflow.

Test Plan:
1. Reset, then lookup PC 0x80000000 → predict_valid_o=0, predict_taken_o=0, busy_o=0.
2. Four taken updates to PC 0x1002 (NR_ENTRIES=16) → counter reaches 10, 11, 11, 11; then two not-taken updates → 10, then 01. Lookup after each step: predict_taken_o = 1,1,1,1,1,0.
3. Update and lookup of PC 0x2004 in the same cycle on an invalid entry → that cycle predict_valid_o=0; next cycle predict_valid_o=1 and predict_taken_o matches the update outcome.
4. update_is_branch_i=0, or debug_mode_i=1, with update_valid_i=1 → table unchanged; lookup still invalid.
5. Populate all 16 entries, pulse flush_bht_i → busy_o=1 for exactly 16 cycles, updates dropped and predict_valid_o=0 throughout; afterwards every entry reads invalid. A second pulse at clear cycle 7 extends busy_o to 7+16 cycles total.
6. Assert rst_i at clear cycle 5 → busy_o=0 immediately. A subsequent update to PC 0x0006 works normally.
